seq_alu: RTL and testbench

Parametrised, registered successor to the single-cycle processor ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus error bit.
- Owns the architectural flag register: flags[2]=V, flags[1]=N, flags[0]=Z.
- Sits between decode/register-read and writeback; the pipeline stalls on in_ready/out_valid.
- Adds optional iterative multi-cycle multiply.

---
 rtl/seq_alu_pkg.sv | 33 +++
 rtl/seq_alu_mul.sv | 59 +++++
 rtl/seq_alu.sv | 217 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode map, FSM states, flag bit positions.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_AGEN0  = 4'h8,
        OP_AGEN1  = 4'h9,
        OP_MUL    = 4'hA,
        OP_RSV_B  = 4'hB,
        OP_RSV_C  = 4'hC,
        OP_RSV_D  = 4'hD,
        OP_RSV_E  = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative signed multiplier: one partial product per cycle, 2*WIDTH accumulator.
// Bit 0 of b is consumed on the start edge, so done rises WIDTH-1 edges later;
// the MSB partial product is subtracted (two's-complement weight of b).
// Only compiled into seq_alu when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_a_ext;

    assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};

    // Shift-and-add iteration, down-counting the remaining multiplier bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= b[0] ? w_a_ext : '0;
            r_mcand  <= w_a_ext << 1;
            r_mplier <= b >> 1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                if (r_mplier[0]) begin
                    r_acc <= (r_cnt == CNT_W'(1)) ? (r_acc - r_mcand) : (r_acc + r_mcand);
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done    = r_busy && (r_cnt == '0);
    assign product = r_acc;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes and the architectural {V,N,Z} flags.
// Optional iterative multiply (opcode 0xA) is built when SEQ_ALU_MUL_EN is defined;
// otherwise 0xA is reserved and every op completes in one cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             err,
    output logic [2:0]       flags
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_err;
    logic [2:0]       r_flags;

    opcode_e          w_op;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_load_single;

    logic [WIDTH-1:0] w_sum, w_diff, w_add_sat, w_sub_sat;
    logic             w_add_ov, w_sub_ov;
    logic [WIDTH-1:0] w_red;
    logic [SHAMT_W-1:0] w_sh;
    logic [SHAMT_W:0]   w_sh_inv;
    logic [WIDTH-1:0] w_sll, w_sra, w_ror, w_padd, w_agen;
    logic [WIDTH-1:0] w_res;
    logic             w_err;
    logic [2:0]       w_flags;

    assign w_op     = opcode_e'(opcode);
    assign w_accept = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_mul_lo, w_mul_hi;
    logic               w_mul_ov;

    assign w_is_mul = (w_op == OP_MUL);
    assign w_mul_lo = w_product[WIDTH-1:0];
    assign w_mul_hi = w_product[2*WIDTH-1:WIDTH];
    assign w_mul_ov = (w_mul_hi != {WIDTH{w_mul_lo[WIDTH-1]}});

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept && w_is_mul),
        .a       (operand1),
        .b       (operand2),
        .done    (w_mul_done),
        .product (w_product)
    );
`else
    assign w_is_mul = 1'b0;
`endif

    assign w_load_single = w_accept && !w_is_mul;

    // Saturating add/subtract: overflow when the result sign disagrees with the operands.
    assign w_sum     = operand1 + operand2;
    assign w_diff    = operand1 - operand2;
    assign w_add_ov  = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (w_sum[WIDTH-1] != operand1[WIDTH-1]);
    assign w_sub_ov  = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (w_diff[WIDTH-1] != operand1[WIDTH-1]);
    assign w_add_sat = w_add_ov ? (operand1[WIDTH-1] ? MIN_NEG : MAX_POS) : w_sum;
    assign w_sub_sat = w_sub_ov ? (operand1[WIDTH-1] ? MIN_NEG : MAX_POS) : w_diff;

    // Shifts; rotate amount of zero makes the left term shift by WIDTH, i.e. vanish.
    assign w_sh     = operand2[SHAMT_W-1:0];
    assign w_sh_inv = (SHAMT_W+1)'(WIDTH) - {1'b0, w_sh};
    assign w_sll    = operand1 << w_sh;
    assign w_sra    = $signed(operand1) >>> w_sh;
    assign w_ror    = (operand1 >> w_sh) | (operand1 << w_sh_inv);

    assign w_agen   = operand1 + {operand2[WIDTH-2:0], 1'b0};

    for (genvar g = 0; g < WIDTH/4; g++) begin : g_nib
        logic [4:0] w_s;
        assign w_s = {operand1[4*g+3], operand1[4*g +: 4]} + {operand2[4*g+3], operand2[4*g +: 4]};
        assign w_padd[4*g +: 4] = (w_s[4] != w_s[3]) ? (w_s[4] ? 4'h8 : 4'h7) : w_s[3:0];
    end

    // Byte-lane reduction; accumulating modulo 2^WIDTH keeps the sign-extended low bits exact.
    always_comb begin
        w_red = '0;
        for (int i = 0; i < WIDTH/8; i++) begin
            w_red = w_red + {{(WIDTH-8){operand1[8*i+7]}}, operand1[8*i +: 8]}
                          + {{(WIDTH-8){operand2[8*i+7]}}, operand2[8*i +: 8]};
        end
    end

    // Single-cycle result, error and next-flag selection.
    always_comb begin
        w_res   = '0;
        w_err   = 1'b0;
        w_flags = r_flags;
        case (w_op)
            OP_ADD: begin
                w_res   = w_add_sat;
                w_flags = {w_add_ov, w_add_sat[WIDTH-1], w_add_sat == '0};
            end
            OP_SUB: begin
                w_res   = w_sub_sat;
                w_flags = {w_sub_ov, w_sub_sat[WIDTH-1], w_sub_sat == '0};
            end
            OP_XOR: begin
                w_res           = operand1 ^ operand2;
                w_flags[FLAG_Z] = ((operand1 ^ operand2) == '0);
            end
            OP_RED:    w_res = w_red;
            OP_SLL: begin
                w_res           = w_sll;
                w_flags[FLAG_Z] = (w_sll == '0);
            end
            OP_SRA: begin
                w_res           = w_sra;
                w_flags[FLAG_Z] = (w_sra == '0);
            end
            OP_ROR: begin
                w_res           = w_ror;
                w_flags[FLAG_Z] = (w_ror == '0);
            end
            OP_PADDSB: w_res = w_padd;
            OP_AGEN0,
            OP_AGEN1:  w_res = w_agen;
`ifdef SEQ_ALU_MUL_EN
            OP_MUL:    w_err = 1'b0;
`endif
            default:   w_err = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? S_EXEC : S_DONE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_EXEC: begin
                if (w_mul_done) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_next = w_is_mul ? S_EXEC : S_DONE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
        out_valid = (r_state == S_DONE);
    end

    // Result/flag registers load only on accept or multiply completion, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
            r_err     <= 1'b0;
            r_flags   <= 3'b000;
        end else if (w_load_single) begin
            r_alu_out <= w_res;
            r_err     <= w_err;
            r_flags   <= w_flags;
`ifdef SEQ_ALU_MUL_EN
        end else if ((r_state == S_EXEC) && w_mul_done) begin
            r_alu_out <= w_mul_lo;
            r_err     <= 1'b0;
            r_flags   <= {w_mul_ov, w_mul_lo[WIDTH-1], w_mul_lo == '0};
`endif
        end
    end

    assign ALU_Out = r_alu_out;
    assign err     = r_err;
    assign flags   = r_flags;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   opcode = 4'h0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALU_Out;
    logic         err;
    logic [2:0]   flags;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .err       (err),
        .flags     (flags)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        logic [2:0]   fl;
        int           acc;
        int           lat;
    } exp_t;

    int           n_vec = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    exp_t         q[$];
    logic [2:0]   m_flags = 3'b000;
    logic [W-1:0] last_res;
    logic         last_err;
    logic [2:0]   last_fl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: operations evaluated as plain signed integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [2:0] fin);
        exp_t   e;
        longint mx, mn, s;
        int     x;
        int     sh;
        e.res = '0;
        e.err = 1'b0;
        e.fl  = fin;
        e.acc = 0;
        e.lat = 1;
        mx = (longint'(1) <<< (W-1)) - 1;
        mn = -mx - 1;
        sh = int'(b[3:0]);
        case (op)
            4'h0, 4'h1: begin
                if (op == 4'h0) s = longint'($signed(a)) + longint'($signed(b));
                else            s = longint'($signed(a)) - longint'($signed(b));
                e.fl[2] = (s > mx) || (s < mn);
                if (s > mx) s = mx;
                if (s < mn) s = mn;
                e.res   = s[W-1:0];
                e.fl[1] = e.res[W-1];
                e.fl[0] = (e.res == 0);
            end
            4'h2: begin
                e.res   = a ^ b;
                e.fl[0] = (e.res == 0);
            end
            4'h3: begin
                s = 0;
                for (int i = 0; i < W/8; i++) begin
                    s = s + longint'($signed(a[8*i +: 8])) + longint'($signed(b[8*i +: 8]));
                end
                e.res = s[W-1:0];
            end
            4'h4: begin
                s = longint'(a) * (longint'(1) <<< sh);
                e.res   = s[W-1:0];
                e.fl[0] = (e.res == 0);
            end
            4'h5: begin
                s = longint'($signed(a)) >>> sh;
                e.res   = s[W-1:0];
                e.fl[0] = (e.res == 0);
            end
            4'h6: begin
                e.res = a;
                for (int i = 0; i < sh; i++) e.res = {e.res[0], e.res[W-1:1]};
                e.fl[0] = (e.res == 0);
            end
            4'h7: begin
                for (int i = 0; i < W/4; i++) begin
                    x = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
                    if (x > 7)  x = 7;
                    if (x < -8) x = -8;
                    e.res[4*i +: 4] = x[3:0];
                end
            end
            4'h8, 4'h9: begin
                s = longint'(a) + 2 * longint'(b);
                e.res = s[W-1:0];
            end
`ifdef SEQ_ALU_MUL_EN
            4'hA: begin
                s = longint'($signed(a)) * longint'($signed(b));
                e.res   = s[W-1:0];
                e.fl[2] = (s > mx) || (s < mn);
                e.fl[1] = e.res[W-1];
                e.fl[0] = (e.res == 0);
                e.lat   = W + 1;
            end
`endif
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, update the model.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ordy);
        logic exp_ov, exp_ir;
        exp_t e;
        in_valid  = v;
        opcode    = op;
        operand1  = a;
        operand2  = b;
        out_ready = ordy;
        @(negedge clk);
        exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
        exp_ir = (q.size() == 0) || (exp_ov && ordy);
        check("out_valid", out_valid, exp_ov);
        check("in_ready", in_ready, exp_ir);
        if (exp_ov && out_valid) begin
            check("ALU_Out", ALU_Out, q[0].res);
            check("err", err, q[0].err);
            check("flags", flags, q[0].fl);
        end
        if (exp_ov && ordy) begin
            last_res = q[0].res;
            last_err = q[0].err;
            last_fl  = q[0].fl;
            void'(q.pop_front());
        end
        if (v && exp_ir) begin
            e       = model(op, a, b, m_flags);
            m_flags = e.fl;
            e.acc   = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 4*W && q.size() > 0; i++) cycle(1'b0, 4'h0, '0, '0, 1'b1);
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        q.delete();
        m_flags = 3'b000;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ALU_Out", ALU_Out, 0);
        check("rst_err", err, 0);
        check("rst_flags", flags, 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cycle(1'b1, op, a, b, 1'b1);
        drain();
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(5))
            0: return '0;
            1: return W'(1);
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        run_op(4'h0, 16'h7FFF, 16'h0001);
        check("add_sat_res", last_res, 16'h7FFF);
        check("add_sat_flags", last_fl, 3'b100);

        run_op(4'h1, 16'h0005, 16'h0005);
        check("sub_zero_res", last_res, 16'h0000);
        check("sub_zero_flags", last_fl, 3'b001);

        run_op(4'h5, 16'h8000, 16'h0004);
        check("sra_res", last_res, 16'hF800);
        check("sra_flags", last_fl, 3'b000);

        run_op(4'h6, 16'h0001, 16'h0001);
        check("ror_res", last_res, 16'h8000);

        run_op(4'h7, 16'h7777, 16'h1111);
        check("paddsb_res", last_res, 16'h7777);
        check("paddsb_flags", last_fl, 3'b000);

        run_op(4'hF, 16'h1234, 16'h5678);
        check("rsv_res", last_res, 16'h0000);
        check("rsv_err", last_err, 1);
        check("rsv_flags", last_fl, 3'b000);

        // Stall with the next op waiting, then release and stream back-to-back.
        cycle(1'b1, 4'h2, 16'hA5A5, 16'h5A5A, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 16'h0010, 16'h0020, 1'b0);
        cycle(1'b1, 4'h0, 16'h0010, 16'h0020, 1'b1);
        cycle(1'b1, 4'h4, 16'h0003, 16'h0005, 1'b1);
        cycle(1'b1, 4'h3, 16'h80FF, 16'h7F01, 1'b1);
        cycle(1'b1, 4'h8, 16'hFFF0, 16'h0010, 1'b1);
        cycle(1'b1, 4'h1, 16'h8000, 16'h0001, 1'b1);
        drain();
        check("b2b_last_res", last_res, 16'h8000);
        check("b2b_last_flags", last_fl, 3'b110);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(3) != 0, 4'($urandom_range(15)), rnd_operand(), rnd_operand(),
                  $urandom_range(3) != 0);
        end
        drain();

`ifdef SEQ_ALU_MUL_EN
        run_op(4'hA, 16'h0003, 16'hFFFE);
        check("mul_neg_res", last_res, 16'hFFFA);
        check("mul_neg_flags", last_fl, 3'b010);

        run_op(4'hA, 16'h4000, 16'h0004);
        check("mul_ov_res", last_res, 16'h0000);
        check("mul_ov_flags", last_fl, 3'b101);

        cycle(1'b1, 4'hA, 16'h1234, 16'h0077, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, '0, '0, 1'b1);
        do_reset();
`else
        run_op(4'hA, 16'h0003, 16'hFFFE);
        check("op_a_reserved_err", last_err, 1);
        check("op_a_reserved_res", last_res, 16'h0000);

        cycle(1'b1, 4'h1, 16'h8000, 16'h0001, 1'b0);
        cycle(1'b0, 4'h0, '0, '0, 1'b0);
        do_reset();
`endif
        run_op(4'h0, 16'h0001, 16'h0002);
        check("post_rst_add", last_res, 16'h0003);
        check("post_rst_flags", last_fl, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
